// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative 32-bit unsigned multiply/divide unit for the execute stage.
//   It sits beside the ALU and takes the same register-file operands.
//   Every operation runs for a fixed 32 cycles: one bit per cycle of
//   shift-add multiply, or one bit per cycle of restoring division.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous, active-low reset
//   start     request a new operation (ignored while busy)
//   op        00 MUL lo, 01 MULHU hi, 10 DIVU quotient, 11 REMU remainder
//   a1        multiplicand / dividend
//   a2        multiplier / divisor
//   busy      operation in progress
//   done      one-cycle pulse, result valid
//   result    selected result, held until the next completion
//   zeroFlag  result == 0
//
// Build option
//   MULDIV_DIV_EN : when defined, DIVU/REMU are implemented. When it is not
//                   defined, ops 10/11 complete at once with result 0.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zeroFlag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [5:0]       count;
    // Shared working register with one guard bit at the top.
    //   multiply: {guard, upper partial product, multiplier/lower product}
    //   divide  : {33-bit remainder, quotient}
    logic [2*WIDTH:0] prod_q;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0] opnd_q;
    // Selects the upper half of prod for MULHU/REMU.
    logic             hi_q;
`ifdef MULDIV_DIV_EN
    logic             div_q;
    logic [2*WIDTH:0] div_shift;
    logic [WIDTH+1:0] div_diff;
`endif

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] prod_step;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        // Guard bit is always zero entering the add, so the 33-bit sum
        // keeps the carry that is shifted back in.
        mul_sum   = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, opnd_q} : '0);
        prod_step = {1'b0, mul_sum, prod_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {prod_q[2*WIDTH-1:0], 1'b0};
        div_diff  = {1'b0, div_shift[2*WIDTH:WIDTH]} - {2'b00, opnd_q};
        if (div_q) begin
            // Restoring step: keep the difference only when it did not borrow.
            if (!div_diff[WIDTH+1])
                prod_step = {div_diff[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
            else
                prod_step = div_shift;
        end
`endif
        // Low half is the product low word or quotient, high half is the
        // product high word or remainder (remainder < divisor fits 32 bits).
        final_res = hi_q ? prod_step[2*WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            hi_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q    <= 1'b0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zeroFlag <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
`ifdef MULDIV_DIV_EN
                        hi_q   <= op[0];
                        div_q  <= op[1];
                        count  <= '0;
                        opnd_q <= op[1] ? a2 : a1;
                        prod_q <= {{(WIDTH+1){1'b0}}, (op[1] ? a1 : a2)};
                        busy   <= 1'b1;
                        state  <= RUN;
`else
                        if (op[1]) begin
                            // No divider: complete immediately with zero.
                            result   <= '0;
                            zeroFlag <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            hi_q   <= op[0];
                            count  <= '0;
                            opnd_q <= a1;
                            prod_q <= {{(WIDTH+1){1'b0}}, a2};
                            busy   <= 1'b1;
                            state  <= RUN;
                        end
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    prod_q <= prod_step;
                    count  <= count + 6'd1;
                    if (count == 6'd31) begin
                        result   <= final_res;
                        zeroFlag <= (final_res == '0);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit. Expected results come from a behavioural
// model using native 64-bit multiply and divide, queued at each accepted
// start and popped when done pulses.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a1 = '0;
    logic [31:0] a2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zeroFlag;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a1       (a1),
        .a2       (a2),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zeroFlag (zeroFlag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        case (o)
            2'b00: return p[31:0];
            2'b01: return p[63:32];
`ifdef MULDIV_DIV_EN
            2'b10: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: return (y == 0) ? x : x % y;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
        return 32;
`else
        return o[1] ? 0 : 32;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge (edge k).
    // Returns at the negedge just after edge k.
    task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        op    = o;
        a1    = x;
        a2    = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a1    = $urandom;
        a2    = $urandom;
        op    = 2'($urandom_range(0, 3));
        e.res = model(o, x, y);
        e.lat = model_lat(o);
        e.t0  = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, cyc - e.t0, e.lat);
            check({tag, "_result"}, result, e.res);
            check({tag, "_zero"}, {31'd0, zeroFlag}, {31'd0, (e.res == 32'd0)});
            check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic done_drops(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    logic [1:0] rst_op;

    initial begin
        // Reset with start low.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zeroFlag}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        // Basic multiply.
        do_start(2'b00, 32'd7, 32'd6);
        wait_done("mul_7x6");
        done_drops("mul_7x6");

        // Full-scale multiply, low then high word.
        do_start(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mul_max");
        done_drops("mul_max");
        do_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mulhu_max");
        done_drops("mulhu_max");

        // Division, including divide by zero.
        do_start(2'b10, 32'd100, 32'd7);
        wait_done("divu_100_7");
        done_drops("divu_100_7");
        do_start(2'b11, 32'd100, 32'd7);
        wait_done("remu_100_7");
        done_drops("remu_100_7");
        do_start(2'b10, 32'h1234, 32'd0);
        wait_done("divu_by0");
        done_drops("divu_by0");
        do_start(2'b11, 32'h1234, 32'd0);
        wait_done("remu_by0");
        done_drops("remu_by0");

        // Start during RUN is ignored; start during DONE is accepted.
        do_start(2'b00, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        op    = 2'b00;
        a1    = 32'd9;
        a2    = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ignored_busy", {31'd0, busy}, 32'd1);
        wait_done("mul_3x5");
        do_start(2'b00, 32'd9, 32'd9);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        check("b2b_busy_high", {31'd0, busy}, 32'd1);
        wait_done("mul_9x9");
        done_drops("mul_9x9");

        // Reset in the middle of an operation.
`ifdef MULDIV_DIV_EN
        rst_op = 2'b10;
`else
        rst_op = 2'b00;
`endif
        do_start(rst_op, 32'd1000, 32'd10);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", {31'd0, zeroFlag}, 32'd1);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        // Release reset with start already high on the first edge.
        rst_n = 1'b1;
        do_start(rst_op, 32'd1000, 32'd10);
        wait_done("after_reset");
        done_drops("after_reset");

        // Mixed operations with random operands.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 2'(i % 4);
            rx = $urandom;
            ry = (i == 6) ? 32'd0 : ($urandom >> (i % 3) * 8);
            do_start(ro, rx, ry);
            wait_done("rand_op");
            done_drops("rand_op");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
